// File: rtl/mixcolumns_iter.sv
// mixcolumns_iter: iterative AES MixColumns / InvMixColumns stage.
// Mixes one 32-bit column per clock through a single shared datapath.
// A full 128-bit state takes four cycles. ready_o pulses once the last
// column has been written.
// Optional feature macro: MIXCOL_LAST_ROUND_EN. When it is defined, the
// last_round_i port exists and a latched last_round_i=1 passes every
// column through unchanged, for the final AES round.
module mixcolumns_iter (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         decrypt_i,
`ifdef MIXCOL_LAST_ROUND_EN
  input  logic         last_round_i,
`endif
  input  logic [127:0] data_i,
  output logic         ready_o,
  output logic [127:0] data_o
);

  // One idle state plus one state per column being mixed.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    COL0 = 3'd1,
    COL1 = 3'd2,
    COL2 = 3'd3,
    COL3 = 3'd4
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] data_reg;
  logic [127:0] data_next;
  logic         mode_dec;
  logic         mode_dec_next;
  logic         ready_next;
  logic [1:0]   col_sel;
  logic [31:0]  col_in;
  logic [31:0]  col_mixed;
  logic [31:0]  col_out;
`ifdef MIXCOL_LAST_ROUND_EN
  logic         mode_last;
  logic         mode_last_next;
`endif

  // GF(2^8) multiply by 2, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte of the matrix product. The byte order is p, q, s, t.
  // Forward:  2p ^ 3q ^ s ^ t
  // Inverse:  0e p ^ 0b q ^ 0d s ^ 09 t
  // Every higher coefficient is built from x2, x4 and x8 terms.
  function automatic logic [7:0] mix_row(input logic [7:0] p,
                                         input logic [7:0] q,
                                         input logic [7:0] s,
                                         input logic [7:0] t,
                                         input logic       dec);
    logic [7:0] p2, p4, p8;
    logic [7:0] q2, q4, q8;
    logic [7:0] s2, s4, s8;
    logic [7:0] t2, t4, t8;
    p2 = xtime(p);  p4 = xtime(p2);  p8 = xtime(p4);
    q2 = xtime(q);  q4 = xtime(q2);  q8 = xtime(q4);
    s2 = xtime(s);  s4 = xtime(s2);  s8 = xtime(s4);
    t2 = xtime(t);  t4 = xtime(t2);  t8 = xtime(t4);
    if (dec)
      mix_row = (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
    else
      mix_row = p2 ^ (q2 ^ q) ^ s ^ t;
  endfunction

  // Map the current column state to the column index it works on.
  always_comb begin
    col_sel = 2'd0;
    case (state)
      COL0:    col_sel = 2'd0;
      COL1:    col_sel = 2'd1;
      COL2:    col_sel = 2'd2;
      COL3:    col_sel = 2'd3;
      default: col_sel = 2'd0;
    endcase
  end

  // Select the column feeding the shared mixing datapath.
  always_comb begin
    col_in = data_reg[127:96];
    case (col_sel)
      2'd0: col_in = data_reg[127:96];
      2'd1: col_in = data_reg[95:64];
      2'd2: col_in = data_reg[63:32];
      2'd3: col_in = data_reg[31:0];
      default: col_in = data_reg[127:96];
    endcase
  end

  // Shared column mixer. Each row uses the same coefficient set,
  // rotated one byte position per row.
  always_comb begin
    col_mixed[31:24] = mix_row(col_in[31:24], col_in[23:16], col_in[15:8],  col_in[7:0],   mode_dec);
    col_mixed[23:16] = mix_row(col_in[23:16], col_in[15:8],  col_in[7:0],   col_in[31:24], mode_dec);
    col_mixed[15:8]  = mix_row(col_in[15:8],  col_in[7:0],   col_in[31:24], col_in[23:16], mode_dec);
    col_mixed[7:0]   = mix_row(col_in[7:0],   col_in[31:24], col_in[23:16], col_in[15:8],  mode_dec);
  end

`ifdef MIXCOL_LAST_ROUND_EN
  // In the final round the column is written back unchanged.
  always_comb begin
    col_out = mode_last ? col_in : col_mixed;
  end
`else
  // Every block is mixed when the last-round feature is absent.
  always_comb begin
    col_out = col_mixed;
  end
`endif

  // Next-state logic: load on start, then write back one column per state.
  always_comb begin
    state_next    = state;
    data_next     = data_reg;
    mode_dec_next = mode_dec;
    ready_next    = 1'b0;
`ifdef MIXCOL_LAST_ROUND_EN
    mode_last_next = mode_last;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          data_next     = data_i;
          mode_dec_next = decrypt_i;
`ifdef MIXCOL_LAST_ROUND_EN
          mode_last_next = last_round_i;
`endif
          state_next    = COL0;
        end
      end
      COL0: begin
        data_next[127:96] = col_out;
        state_next        = COL1;
      end
      COL1: begin
        data_next[95:64] = col_out;
        state_next       = COL2;
      end
      COL2: begin
        data_next[63:32] = col_out;
        state_next       = COL3;
      end
      COL3: begin
        data_next[31:0] = col_out;
        ready_next      = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, data and mode registers. Reset asserts asynchronously and
  // aborts any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data_reg <= '0;
      mode_dec <= 1'b0;
      ready_o  <= 1'b0;
`ifdef MIXCOL_LAST_ROUND_EN
      mode_last <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      data_reg <= data_next;
      mode_dec <= mode_dec_next;
      ready_o  <= ready_next;
`ifdef MIXCOL_LAST_ROUND_EN
      mode_last <= mode_last_next;
`endif
    end
  end

  assign data_o = data_reg;

endmodule

// File: tb/tb_mixcolumns_iter.sv
// tb_mixcolumns_iter: scoreboard bench for mixcolumns_iter.
// Expected results are computed by a matrix-product reference model over
// GF(2^8) and pushed into a queue when a block is issued. A monitor
// compares data_o against the queue on every ready_o pulse.
module tb_mixcolumns_iter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic         decrypt_i = 1'b0;
  logic         last_round_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         ready_o;
  logic [127:0] data_o;

`ifdef MIXCOL_LAST_ROUND_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];

  mixcolumns_iter dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .decrypt_i (decrypt_i),
`ifdef MIXCOL_LAST_ROUND_EN
    .last_round_i (last_round_i),
`endif
    .data_i    (data_i),
    .ready_o   (ready_o),
    .data_o    (data_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Generic GF(2^8) product: carry-less multiply, then reduce by 0x11b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Reference MixColumns / InvMixColumns as a matrix product per column.
  function automatic logic [127:0] mix_model(input logic [127:0] d, input bit dec);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   acc;
    logic [127:0] res;
    logic [31:0]  col;
    if (dec) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      col = d[127 - 32*c -: 32];
      for (int r = 0; r < 4; r++) a[r] = col[31 - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k - r + 4) % 4], a[k]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_ready: data_o %h, required no pulse", data_o);
      end else begin
        checkOutput("result", data_o, exp_q.pop_front());
      end
    end
  end

  // Issue one block and check that ready_o comes 4 cycles after the start edge.
  // The task returns at the negedge of the ready cycle.
  task automatic applyStimulus(input logic [127:0] d, input bit dec, input bit last,
                               input logic [127:0] req);
    int lat;
    start_i      = 1'b1;
    data_i       = d;
    decrypt_i    = dec;
    last_round_i = last;
    exp_q.push_back(req);
    @(negedge clk);
    start_i      = 1'b0;
    data_i       = rand128();
    decrypt_i    = ~dec;
    last_round_i = ~last;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready_o) break;
    end
    checkOutput("latency", 128'(lat), 128'd4);
  endtask

  // Issue a block whose expected value comes from the reference model.
  task automatic applyRandom(input bit dec, input bit last);
    logic [127:0] d;
    logic [127:0] req;
    d   = rand128();
    req = (LastEn && last) ? d : mix_model(d, dec);
    applyStimulus(d, dec, last, req);
  endtask

  initial begin
    logic [127:0] vec[10];
    int pulses;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset_data", data_o, 128'd0);
    checkOutput("reset_ready", 128'(ready_o), 128'd0);
    reset = 1'b1;
    @(negedge clk);

    // Known vectors.
    applyStimulus(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                  128'h046681e5e0cb199a48f8d37a2806264c);
    applyStimulus(128'hdb135345f20a225c010101012d26314c, 1'b0, 1'b0,
                  128'h8e4da1bc9fdc589d010101014d7ebdf8);
    applyStimulus(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5);

    // Result holding while idle with a changing data_i.
    repeat (3) begin
      data_i = rand128();
      @(negedge clk);
    end
    checkOutput("hold", data_o, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

`ifdef MIXCOL_LAST_ROUND_EN
    applyStimulus(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b1,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5);
    applyStimulus(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                  128'h046681e5e0cb199a48f8d37a2806264c);
`endif

    // Randomized blocks, back to back and with idle gaps.
    for (int i = 0; i < 24; i++) begin
      applyRandom(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i % 3 == 2) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // start_i held high for 10 cycles: starts are accepted only from IDLE,
    // so the data presented at the first and sixth edges are the blocks mixed.
    for (int k = 0; k < 10; k++) vec[k] = rand128();
    exp_q.push_back(mix_model(vec[0], 1'b0));
    exp_q.push_back(mix_model(vec[5], 1'b0));
    pulses = 0;
    start_i      = 1'b1;
    decrypt_i    = 1'b0;
    last_round_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_i = vec[k];
      @(negedge clk);
      if (ready_o) pulses++;
    end
    start_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    checkOutput("held_start_pulses", 128'(pulses), 128'd2);

    // Reset in the middle of COL2: outputs clear at once, no pulse later.
    start_i = 1'b1;
    data_i  = rand128();
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midreset_ready", 128'(ready_o), 128'd0);
    checkOutput("midreset_data", data_o, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    checkOutput("post_reset_pulses", 128'(pulses), 128'd0);

    // Normal operation after the abort.
    applyRandom(1'b0, 1'b0);
    applyRandom(1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
